// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if
// Groups the per-channel divider/reset-sequencer signals of clk_rst_seq so
// the sequencer and whoever drives it share one bundle.
//   div_val     : divider values, channel k at [k*DIV_W +: DIV_W]
//   div_load    : per-channel pulse, latch div_val into the channel shadow
//   sw_rst_req  : per-channel pulse, request a local channel reset
//   ch_clk_en   : per-channel one-cycle enable per divided period
//   ch_clk      : per-channel divided clock level
//   ch_reset_n  : per-channel active-low reset
//   seq_done    : all channels released after the global reset
//   busy        : channel is inside a software reset hold
// The master modport belongs to the requester, the slave modport to the
// sequencer itself.
interface clk_rst_seq_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       sw_rst_req;
  logic [NUM_CH-1:0]       ch_clk_en;
  logic [NUM_CH-1:0]       ch_clk;
  logic [NUM_CH-1:0]       ch_reset_n;
  logic                    seq_done;
  logic [NUM_CH-1:0]       busy;

  modport master (
    output div_val, div_load, sw_rst_req,
    input  ch_clk_en, ch_clk, ch_reset_n, seq_done, busy
  );

  modport slave (
    input  div_val, div_load, sw_rst_req,
    output ch_clk_en, ch_clk, ch_reset_n, seq_done, busy
  );
endinterface

// File: rtl/clk_rst_seq.sv
// clk_rst_seq
// Clock-enable and reset sequencer. After the global reset drops, every
// channel is held in reset for HOLD_CYCLES clocks and then released one by
// one, STAGGER clocks apart. Once all channels are out of reset, each one
// can be put back into a local reset by software. Every released channel
// runs a programmable divider that produces an enable pulse per period and
// a divided clock level.
// Ports:
//   clk   : system clock, everything on the rising edge
//   reset : synchronous active-high global reset
//   bus   : clk_rst_seq_if slave modport (divider values/loads, software
//           reset requests, channel enables/clocks/resets, seq_done, busy)
module clk_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DIV_RESET   = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGGER     = 4
) (
  input logic          clk,
  input logic          reset,
  clk_rst_seq_if.slave bus
);

  localparam int SEQ_MAX = HOLD_CYCLES + (NUM_CH - 1) * STAGGER + 1;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [SEQ_W-1:0]  SEQ_SAT     = SEQ_W'(SEQ_MAX);
  localparam logic [SEQ_W-1:0]  SEQ_HOLD    = SEQ_W'(HOLD_CYCLES);
  localparam logic [SEQ_W-1:0]  SEQ_ONE     = SEQ_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [DIV_W-1:0]  DIV_INIT    = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0]  DIV_ONE     = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } seqState_t;

  seqState_t        state_q, state_d;
  logic [SEQ_W-1:0] seqCnt_q, seqCnt_d;
  logic             seqDone_q, seqDone_d;

  logic [NUM_CH-1:0] rstN_q, rstN_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] clkEn_q, clkEn_d;
  logic [NUM_CH-1:0] chClk_q, chClk_d;
  logic [HOLD_W-1:0] holdCnt_q [NUM_CH];
  logic [HOLD_W-1:0] holdCnt_d [NUM_CH];
  logic [DIV_W-1:0]  shadow_q  [NUM_CH];
  logic [DIV_W-1:0]  shadow_d  [NUM_CH];
  logic [DIV_W-1:0]  divCnt_q  [NUM_CH];
  logic [DIV_W-1:0]  divCnt_d  [NUM_CH];

  // Global sequence: seqCnt counts clocks since reset dropped and saturates
  // one past the last channel release. The FSM state and seq_done are
  // derived from the next count so they line up with the registered
  // channel releases computed from the same value.
  always_comb begin
    seqCnt_d = seqCnt_q;
    state_d  = state_q;
    if (seqCnt_q != SEQ_SAT) begin
      seqCnt_d = seqCnt_q + SEQ_ONE;
    end
    unique case (state_q)
      ST_HOLD:    if (seqCnt_d >= SEQ_HOLD) state_d = ST_RELEASE;
      ST_RELEASE: if (seqCnt_d == SEQ_SAT) state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_HOLD;
    endcase
    seqDone_d = (state_d == ST_DONE);
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      seqCnt_q  <= '0;
      seqDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seqCnt_q  <= seqCnt_d;
      seqDone_q <= seqDone_d;
    end
  end

  // Per-channel next state. Before DONE the channel reset simply follows
  // the staggered release threshold and software requests are dropped.
  // In DONE a request (re)starts a HOLD_CYCLES hold. The divider is frozen
  // at zero whenever the channel is in reset now or is entering reset on
  // this edge, so no enable ever coincides with a falling channel reset.
  // A load restarts the count and suppresses the enable of that edge, so a
  // load on a wrap cannot produce a double pulse.
  always_comb begin : chanNext
    logic [DIV_W-1:0] effDiv;
    logic             wrap;
    effDiv  = '0;
    wrap    = 1'b0;
    rstN_d  = rstN_q;
    busy_d  = busy_q;
    clkEn_d = '0;
    chClk_d = chClk_q;
    for (int k = 0; k < NUM_CH; k++) begin
      holdCnt_d[k] = holdCnt_q[k];
      shadow_d[k]  = shadow_q[k];
      divCnt_d[k]  = divCnt_q[k];

      if (state_q != ST_DONE) begin
        rstN_d[k] = (int'(seqCnt_d) >= HOLD_CYCLES + k * STAGGER);
        busy_d[k] = 1'b0;
      end else if (bus.sw_rst_req[k]) begin
        rstN_d[k]    = 1'b0;
        busy_d[k]    = 1'b1;
        holdCnt_d[k] = HOLD_RELOAD;
      end else if (busy_q[k]) begin
        if (holdCnt_q[k] == '0) begin
          rstN_d[k] = 1'b1;
          busy_d[k] = 1'b0;
        end else begin
          holdCnt_d[k] = holdCnt_q[k] - HOLD_ONE;
        end
      end else begin
        rstN_d[k] = 1'b1;
      end

      if (bus.div_load[k]) begin
        shadow_d[k] = bus.div_val[k*DIV_W +: DIV_W];
      end

      effDiv = (shadow_q[k] == '0) ? DIV_ONE : shadow_q[k];
      wrap   = (divCnt_q[k] == effDiv - DIV_ONE);

      if (!rstN_q[k] || !rstN_d[k]) begin
        divCnt_d[k] = '0;
        chClk_d[k]  = 1'b0;
      end else if (bus.div_load[k]) begin
        divCnt_d[k] = '0;
      end else if (wrap) begin
        divCnt_d[k] = '0;
        clkEn_d[k]  = 1'b1;
        chClk_d[k]  = ~chClk_q[k];
      end else begin
        divCnt_d[k] = divCnt_q[k] + DIV_ONE;
      end
    end
  end

  // Per-channel registers. Global reset restores the divider shadow to
  // DIV_RESET and discards any pending load or software hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rstN_q  <= '0;
      busy_q  <= '0;
      clkEn_q <= '0;
      chClk_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        holdCnt_q[k] <= '0;
        shadow_q[k]  <= DIV_INIT;
        divCnt_q[k]  <= '0;
      end
    end else begin
      rstN_q  <= rstN_d;
      busy_q  <= busy_d;
      clkEn_q <= clkEn_d;
      chClk_q <= chClk_d;
      for (int k = 0; k < NUM_CH; k++) begin
        holdCnt_q[k] <= holdCnt_d[k];
        shadow_q[k]  <= shadow_d[k];
        divCnt_q[k]  <= divCnt_d[k];
      end
    end
  end

  assign bus.ch_reset_n = rstN_q;
  assign bus.busy       = busy_q;
  assign bus.ch_clk_en  = clkEn_q;
  assign bus.ch_clk     = chClk_q;
  assign bus.seq_done   = seqDone_q;

endmodule
